three2add: RTL and testbench

//  - Registered 3:2 carry-save compressor for FPU mantissa datapaths.
//  - Reduces three (n+1)-bit operands plus a carry-in to a redundant pair (t, s)

---
 rtl/three2add_pkg.sv | 10 +
 rtl/three2add_if.sv | 36 +++
 rtl/three2add_fa_cell.sv | 15 +
 rtl/three2add.sv | 69 ++++++
 tb/tb_three2add.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/three2add_pkg.sv
// Shared constants and helpers for the three2add carry-save compressor.
package three2add_pkg;

  localparam int THREE2ADD_N = 11;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/three2add_if.sv
// Operand/result bundle for three2add; the optional sum port exists only when
// THREE2ADD_RESOLVE_EN is defined.
interface three2add_if #(
  parameter int n = three2add_pkg::THREE2ADD_N
);
  // Handshake: in_valid qualifies a/b/c/c_in for one cycle; there is no ready,
  // the compressor accepts a set every cycle and out_valid follows one cycle later.
  logic         in_valid;
  logic [n:0]   a;
  logic [n:0]   b;
  logic [n:0]   c;
  logic         c_in;
  logic         out_valid;
  logic [n+1:0] t;
  logic [n+1:0] s;
`ifdef THREE2ADD_RESOLVE_EN
  logic [n+2:0] sum;
`endif

  modport master (
    output in_valid, a, b, c, c_in,
`ifdef THREE2ADD_RESOLVE_EN
    input  sum,
`endif
    input  out_valid, t, s
  );

  modport slave (
    input  in_valid, a, b, c, c_in,
`ifdef THREE2ADD_RESOLVE_EN
    output sum,
`endif
    output out_valid, t, s
  );

endinterface

// File: rtl/three2add_fa_cell.sv
// One-bit full adder: sum is the parity of the three inputs, carry their majority.
module three2add_fa_cell
  import three2add_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic z,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y ^ z;
  assign carry = maj3(x, y, z);

endmodule

// File: rtl/three2add.sv
// Registered 3:2 carry-save compressor: t + s == a + b + c + c_in, one cycle latency.
// Define THREE2ADD_RESOLVE_EN to add a registered carry-propagated sum output.
module three2add
  import three2add_pkg::*;
#(
  parameter int n = THREE2ADD_N
) (
  input  logic        clk,
  input  logic        rst,
  three2add_if.slave  bus
);

  logic [n+1:0] s_nxt;
  logic [n+1:0] t_nxt;
  logic [n+1:0] s_q;
  logic [n+1:0] t_q;
  logic         out_valid_q;

  // Carry of bit i lands at weight i+1, freeing t[0] to carry c_in in for free.
  for (genvar i = 0; i <= n; i++) begin : g_fa
    three2add_fa_cell u_fa_cell (
      .x     (bus.a[i]),
      .y     (bus.b[i]),
      .z     (bus.c[i]),
      .sum   (s_nxt[i]),
      .carry (t_nxt[i+1])
    );
  end

  assign s_nxt[n+1] = 1'b0;
  assign t_nxt[0]   = bus.c_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        t_q <= t_nxt;
        s_q <= s_nxt;
      end
    end
  end

  assign bus.t         = t_q;
  assign bus.s         = s_q;
  assign bus.out_valid = out_valid_q;

`ifdef THREE2ADD_RESOLVE_EN
  logic [n+2:0] sum_nxt;
  logic [n+2:0] sum_q;

  assign sum_nxt = {2'b00, bus.a} + {2'b00, bus.b} + {2'b00, bus.c}
                 + {{(n+2){1'b0}}, bus.c_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (bus.in_valid) begin
      sum_q <= sum_nxt;
    end
  end

  assign bus.sum = sum_q;
`endif

endmodule

// File: tb/tb_three2add.sv
// Directed plus randomized bench for three2add against a word-level arithmetic model.
module tb_three2add;
  import three2add_pkg::*;

  localparam int N = THREE2ADD_N;
  localparam int W = N + 2;

  typedef struct packed {
    logic         ov;
    logic [W-1:0] t;
    logic [W-1:0] s;
    logic [W:0]   tot;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  three2add_if #(.n(N)) bus ();

  three2add #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state: what the outputs should show after the next edge
  exp_t exp_q[$];
  exp_t m;

  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [N:0] a,
                            input logic [N:0] b, input logic [N:0] c, input logic ci);
    int total;
    if (r) begin
      m = '0;
    end else begin
      m.ov = v;
      if (v) begin
        total = int'(a) + int'(b) + int'(c) + int'(ci);
        m.s   = W'(a ^ b ^ c);
        m.t   = {((a & b) | (a & c) | (b & c)), ci};
        m.tot = (W+1)'(total);
      end
    end
    exp_q.push_back(m);
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    logic [W:0] pair;
    e    = exp_q.pop_front();
    pair = {1'b0, bus.t} + {1'b0, bus.s};
    chk({tag, "_ov"}, {{W{1'b0}}, bus.out_valid}, {{W{1'b0}}, e.ov});
    chk({tag, "_t"}, {1'b0, bus.t}, {1'b0, e.t});
    chk({tag, "_s"}, {1'b0, bus.s}, {1'b0, e.s});
    chk({tag, "_ts"}, pair, e.tot);
`ifdef THREE2ADD_RESOLVE_EN
    chk({tag, "_sum"}, bus.sum, e.tot);
`endif
  endtask

  // driver: inputs change on the falling edge, outputs are sampled 1 after rising
  task automatic apply(input string tag, input logic r, input logic v, input logic [N:0] a,
                       input logic [N:0] b, input logic [N:0] c, input logic ci);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.c        = c;
    bus.c_in     = ci;
    model_step(r, v, a, b, c, ci);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic         r;
    logic         v;
    logic [N:0]   ra, rb, rc;
    logic         rci;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.c        = '0;
    bus.c_in     = 1'b0;
    m            = '0;

    // reset state, with in_valid high to show it is ignored under reset
    apply("rst0", 1'b1, 1'b0, '0, '0, '0, 1'b0);
    apply("rst1", 1'b1, 1'b1, 12'h123, 12'h456, 12'h789, 1'b1);
    chk("rst_t_zero", {1'b0, bus.t}, '0);

    // directed vectors with hand-derived results
    apply("d1", 1'b0, 1'b1, 12'h001, 12'h002, 12'h004, 1'b0);
    chk("d1_s_const", {1'b0, bus.s}, 14'h0007);
    chk("d1_t_const", {1'b0, bus.t}, 14'h0000);
    chk("d1_ts_const", {1'b0, bus.t} + {1'b0, bus.s}, 14'd7);

    apply("d2", 1'b0, 1'b1, 12'hFFF, 12'h001, 12'h001, 1'b0);
    chk("d2_s_const", {1'b0, bus.s}, 14'h0FFF);
    chk("d2_t_const", {1'b0, bus.t}, 14'h0002);
    chk("d2_ts_const", {1'b0, bus.t} + {1'b0, bus.s}, 14'd4097);

    apply("d3", 1'b0, 1'b1, 12'h555, 12'hAAA, 12'h666, 1'b0);
    chk("d3_s_const", {1'b0, bus.s}, 14'h0999);
    chk("d3_t_const", {1'b0, bus.t}, 14'h0CCC);
    chk("d3_ts_const", {1'b0, bus.t} + {1'b0, bus.s}, 14'd5733);

    apply("d4", 1'b0, 1'b1, 12'h000, 12'h000, 12'h000, 1'b1);
    chk("d4_s_const", {1'b0, bus.s}, 14'h0000);
    chk("d4_t_const", {1'b0, bus.t}, 14'h0001);

    // in_valid low: out_valid drops, t/s hold the c_in-only result
    apply("hold", 1'b0, 1'b0, 12'hABC, 12'hDEF, 12'h123, 1'b0);
    chk("hold_t_const", {1'b0, bus.t}, 14'h0001);
    chk("hold_ov_const", {13'd0, bus.out_valid}, 14'd0);

    // largest operands: carry out of the top bit
    apply("max", 1'b0, 1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1);
    chk("max_ts_const", {1'b0, bus.t} + {1'b0, bus.s}, 14'd12286);

    // reset mid-stream discards the in-flight set
    apply("mid0", 1'b0, 1'b1, 12'h3C3, 12'h5A5, 12'h0F0, 1'b1);
    apply("mid_rst", 1'b1, 1'b1, 12'h7FF, 12'h001, 12'h800, 1'b1);
    chk("mid_rst_s_zero", {1'b0, bus.s}, '0);

    // randomized vectors with random stalls and rare resets
    for (int i = 0; i < 1000; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 3) != 0);
      ra  = N'($urandom_range(0, (1 << (N + 1)) - 1));
      rb  = N'($urandom_range(0, (1 << (N + 1)) - 1));
      rc  = N'($urandom_range(0, (1 << (N + 1)) - 1));
      rci = 1'($urandom_range(0, 1));
      apply("rnd", r, v, ra, rb, rc, rci);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
